// File: rtl/front_panel_encoders_if.sv
// CPU-side register/event port of front_panel_encoders.
//   event_rd_stb  : pop the event FIFO head (one-cycle pulse)
//   status_rd_stb : clear the sticky overflow/decode_err bits (one-cycle pulse)
//   event_data    : FIFO head word, meaningful while status_reg[0] is set
//   status_reg    : {count[3:0], decode_err, overflow, full, not_empty}
//   irq           : registered, high while FIFO not empty or any sticky bit set
// master = CPU / SPI register block, slave = front_panel_encoders.
interface front_panel_encoders_if;
  logic       event_rd_stb;
  logic       status_rd_stb;
  logic [7:0] event_data;
  logic [7:0] status_reg;
  logic       irq;

  modport master (
    output event_rd_stb, status_rd_stb,
    input  event_data, status_reg, irq
  );

  modport slave (
    input  event_rd_stb, status_rd_stb,
    output event_data, status_reg, irq
  );
endinterface

// File: rtl/front_panel_encoders.sv
// Multi-channel front-panel encoder interface. Each channel synchronises and
// debounces raw A/B/switch pins, quadrature-decodes A/B and reports rotation
// and switch events as 8-bit words through a per-channel 2-entry pending
// buffer into a shared event FIFO read by the CPU.
// Ports:
//   clk, spi_reset_n         : system clock, async active-low reset
//   encoder_A/B/sw[NUM_ENC]  : raw front-panel pins
//   position                 : per-channel signed detent counters
//   cpu (slave modport)      : event/status read strobes, event_data,
//                              status_reg, irq
// Build option: define FP_POSITION_EN to include the detent position
// counters; without it position is tied to zero.
// Event word: {channel[2:0], click, dir, switch_level, type, 1'b0}.
module front_panel_encoders #(
  parameter int NUM_ENC         = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 8,
  parameter int POS_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         spi_reset_n,
  input  logic [NUM_ENC-1:0]           encoder_A,
  input  logic [NUM_ENC-1:0]           encoder_B,
  input  logic [NUM_ENC-1:0]           encoder_sw,
  output logic [NUM_ENC*POS_WIDTH-1:0] position,
  front_panel_encoders_if.slave        cpu
);
  localparam int NB   = 3 * NUM_ENC;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  // Gray {B,A} to linear phase so that cw is +1 and ccw is -1 modulo 4.
  function automatic logic [1:0] g2p(input logic [1:0] s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge spi_reset_n)
    if (!spi_reset_n) rst_sync_q <= 2'b00;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  // Bit layout of all per-pin vectors: [A | B | sw], each NUM_ENC wide.
  logic [NB-1:0] raw, sync1_q, sync2_q, cand_q, cand_d, acc_q, acc_d, acc_vld_q, acc_vld_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  assign raw = {encoder_sw, encoder_B, encoder_A};

  // Down-counter reloads on every change of the synchronised value; the
  // candidate is accepted once the counter sits at zero.
  always_comb begin
    cand_d    = sync2_q;
    acc_d     = acc_q;
    acc_vld_d = acc_vld_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] != cand_q[i])  cnt_d[i] = DB_LOAD;
      else if (cnt_q[i] != '0)      cnt_d[i] = cnt_q[i] - CW'(1);
      else begin
        acc_d[i]     = cand_q[i];
        acc_vld_d[i] = 1'b1;
      end
    end
  end

  logic [NUM_ENC-1:0] rot_ev, sw_ev, err_ev;
  logic [7:0]         rot_word [NUM_ENC];
  logic [7:0]         sw_word  [NUM_ENC];
  logic [1:0]         old_s, new_s, p_diff;

  // Events are only raised once both the old and new values are real
  // accepted values; the first acceptance after reset just loads state.
  always_comb begin
    rot_ev = '0;
    sw_ev  = '0;
    err_ev = '0;
    old_s  = 2'b00;
    new_s  = 2'b00;
    p_diff = 2'b00;
    for (int ch = 0; ch < NUM_ENC; ch++) begin
      old_s  = {acc_q[NUM_ENC+ch], acc_q[ch]};
      new_s  = {acc_d[NUM_ENC+ch], acc_d[ch]};
      p_diff = g2p(new_s) - g2p(old_s);
      if (acc_vld_q[ch] && acc_vld_q[NUM_ENC+ch]) begin
        rot_ev[ch] = (p_diff == 2'd1) || (p_diff == 2'd3);
        err_ev[ch] = (p_diff == 2'd2);
      end
      rot_word[ch] = {3'(ch), new_s == 2'b00, p_diff == 2'd1, 3'b000};
      sw_ev[ch]    = acc_vld_q[2*NUM_ENC+ch] && (acc_d[2*NUM_ENC+ch] != acc_q[2*NUM_ENC+ch]);
      sw_word[ch]  = {3'(ch), 2'b00, acc_d[2*NUM_ENC+ch], 2'b10};
    end
  end

  logic [7:0] pend_q [NUM_ENC][2];
  logic [7:0] pend_d [NUM_ENC][2];
  logic [1:0] pend_cnt_q [NUM_ENC];
  logic [1:0] pend_cnt_d [NUM_ENC];
  logic [1:0] pcnt;
  logic       push, pend_ovf;
  logic [7:0] push_word;

  // The lowest channel with a pending word wins the single FIFO push slot;
  // that channel's freed entry is reusable by events arriving this cycle.
  always_comb begin
    push      = 1'b0;
    push_word = 8'h00;
    pend_ovf  = 1'b0;
    pcnt      = 2'd0;
    for (int ch = 0; ch < NUM_ENC; ch++) begin
      pend_d[ch] = pend_q[ch];
      pcnt       = pend_cnt_q[ch];
      if (!push && pcnt != 2'd0) begin
        push          = 1'b1;
        push_word     = pend_q[ch][0];
        pend_d[ch][0] = pend_q[ch][1];
        pcnt          = pcnt - 2'd1;
      end
      if (rot_ev[ch]) begin
        if (pcnt == 2'd2) pend_ovf = 1'b1;
        else begin
          pend_d[ch][pcnt[0]] = rot_word[ch];
          pcnt                = pcnt + 2'd1;
        end
      end
      if (sw_ev[ch]) begin
        if (pcnt == 2'd2) pend_ovf = 1'b1;
        else begin
          pend_d[ch][pcnt[0]] = sw_word[ch];
          pcnt                = pcnt + 2'd1;
        end
      end
      pend_cnt_d[ch] = pcnt;
    end
  end

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] fcnt_q, fcnt_d;
  logic            ovf_q, ovf_d, err_q, err_d, irq_q, irq_d;
  logic            pop, full, wr_ok;
  logic [4:0]      fcnt_ext;

  // A pop frees the slot in the same cycle, so push-on-full with pop is legal.
  always_comb begin
    full     = (fcnt_q == CNTW'(FIFO_DEPTH));
    pop      = cpu.event_rd_stb && (fcnt_q != '0);
    wr_ok    = push && (!full || pop);
    mem_d    = mem_q;
    if (wr_ok) mem_d[wr_ptr_q] = push_word;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    fcnt_d   = fcnt_q + CNTW'(wr_ok) - CNTW'(pop);
    // A new set overrides a clear arriving in the same cycle.
    ovf_d    = (ovf_q & ~cpu.status_rd_stb) | (push & ~wr_ok) | pend_ovf;
    err_d    = (err_q & ~cpu.status_rd_stb) | (|err_ev);
    irq_d    = (fcnt_d != '0) | ovf_d | err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      acc_vld_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= DB_LOAD;
      for (int ch = 0; ch < NUM_ENC; ch++) begin
        pend_q[ch][0]  <= 8'h00;
        pend_q[ch][1]  <= 8'h00;
        pend_cnt_q[ch] <= 2'd0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      acc_q      <= acc_d;
      acc_vld_q  <= acc_vld_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign fcnt_ext       = 5'(fcnt_q);
  assign cpu.status_reg = {(fcnt_ext > 5'd15) ? 4'hF : fcnt_ext[3:0], err_q, ovf_q, full, fcnt_q != '0};
  assign cpu.event_data = (fcnt_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign cpu.irq        = irq_q;

`ifdef FP_POSITION_EN
  logic [POS_WIDTH-1:0] pos_q [NUM_ENC];
  logic [POS_WIDTH-1:0] pos_d [NUM_ENC];

  // Counts every click, including ones whose event word was dropped.
  always_comb begin
    for (int ch = 0; ch < NUM_ENC; ch++) begin
      pos_d[ch] = pos_q[ch];
      if (rot_ev[ch] && rot_word[ch][4])
        pos_d[ch] = rot_word[ch][3] ? pos_q[ch] + POS_WIDTH'(1) : pos_q[ch] - POS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int ch = 0; ch < NUM_ENC; ch++) pos_q[ch] <= '0;
    else        pos_q <= pos_d;
  end

  always_comb begin
    position = '0;
    for (int ch = 0; ch < NUM_ENC; ch++) position[ch*POS_WIDTH +: POS_WIDTH] = pos_q[ch];
  end
`else
  assign position = '0;
`endif
endmodule

// File: tb/tb_front_panel_encoders.sv
module tb_front_panel_encoders;
  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int FD   = 8;
  localparam int PW   = 8;
  localparam int HOLD = 12;
`ifdef FP_POSITION_EN
  localparam logic [15:0] EXP_POS_DETENT = 16'h0100;
  localparam logic [7:0]  EXP_POS_WRAP   = 8'h81;
`else
  localparam logic [15:0] EXP_POS_DETENT = 16'h0000;
  localparam logic [7:0]  EXP_POS_WRAP   = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  enc_a = '0, enc_b = '0, enc_sw = '0;
  logic [N*PW-1:0] position;
  int checks = 0;
  int errors = 0;

  front_panel_encoders_if cpu_if ();

  front_panel_encoders #(
    .NUM_ENC(N), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD), .POS_WIDTH(PW)
  ) dut (
    .clk(clk), .spi_reset_n(rst_n), .encoder_A(enc_a), .encoder_B(enc_b),
    .encoder_sw(enc_sw), .position(position), .cpu(cpu_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    rst_n = 1'b0;
    enc_a = a; enc_b = b; enc_sw = '0;
    cpu_if.event_rd_stb = 1'b0;
    cpu_if.status_rd_stb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(HOLD);
  endtask

  task automatic step(input int ch, input logic [1:0] ba);
    enc_a[ch] = ba[0];
    enc_b[ch] = ba[1];
    tick(HOLD);
  endtask

  task automatic pop_one;
    cpu_if.event_rd_stb = 1'b1;
    @(negedge clk);
    cpu_if.event_rd_stb = 1'b0;
  endtask

  task automatic clear_status;
    cpu_if.status_rd_stb = 1'b1;
    @(negedge clk);
    cpu_if.status_rd_stb = 1'b0;
  endtask

  task automatic test_reset;
    do_reset('1, '1);
    tick(2*DB);
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", cpu_if.irq); end
    checks++; if (cpu_if.event_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", cpu_if.event_data); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL reset_position got %h exp 0000", position); end
  endtask

  task automatic test_cw_detent;
    logic [7:0] exp_w [4];
    exp_w[0] = 8'h28; exp_w[1] = 8'h28; exp_w[2] = 8'h28; exp_w[3] = 8'h38;
    do_reset('0, '0);
    step(1, 2'b01); step(1, 2'b11); step(1, 2'b10); step(1, 2'b00);
    checks++; if (cpu_if.status_reg !== 8'h41) begin errors++; $display("FAIL detent_status got %h exp 41", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b1) begin errors++; $display("FAIL detent_irq got %b exp 1", cpu_if.irq); end
    checks++; if (position !== EXP_POS_DETENT) begin errors++; $display("FAIL detent_position got %h exp %h", position, EXP_POS_DETENT); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cpu_if.event_data !== exp_w[i]) begin errors++; $display("FAIL detent_word%0d got %h exp %h", i, cpu_if.event_data, exp_w[i]); end
      pop_one();
    end
    tick(1);
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL detent_drained got %h exp 00", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b0) begin errors++; $display("FAIL detent_irq_off got %b exp 0", cpu_if.irq); end
  endtask

  task automatic test_glitch_and_err;
    do_reset('0, '0);
    enc_a[0] = 1'b1; tick(2); enc_a[0] = 1'b0; tick(HOLD);
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL glitch_status got %h exp 00", cpu_if.status_reg); end
    enc_a[0] = 1'b1; enc_b[0] = 1'b1; tick(HOLD);
    checks++; if (cpu_if.status_reg !== 8'h08) begin errors++; $display("FAIL twobit_status got %h exp 08", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b1) begin errors++; $display("FAIL twobit_irq got %b exp 1", cpu_if.irq); end
    clear_status();
    tick(1);
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL err_clear got %h exp 00", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b0) begin errors++; $display("FAIL err_clear_irq got %b exp 0", cpu_if.irq); end
  endtask

  task automatic test_switch_simul;
    do_reset('0, '0);
    enc_sw = 2'b11; tick(HOLD);
    checks++; if (cpu_if.status_reg !== 8'h21) begin errors++; $display("FAIL sw_status got %h exp 21", cpu_if.status_reg); end
    checks++; if (cpu_if.event_data !== 8'h06) begin errors++; $display("FAIL sw_first got %h exp 06", cpu_if.event_data); end
    pop_one();
    checks++; if (cpu_if.event_data !== 8'h26) begin errors++; $display("FAIL sw_second got %h exp 26", cpu_if.event_data); end
    pop_one();
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL sw_drained got %h exp 00", cpu_if.status_reg); end
  endtask

  task automatic test_fifo_overflow;
    do_reset('0, '0);
    for (int i = 0; i < FD + 3; i++) begin
      enc_sw[0] = ~enc_sw[0];
      tick(HOLD);
    end
    checks++; if (cpu_if.status_reg !== 8'h87) begin errors++; $display("FAIL ovf_status got %h exp 87", cpu_if.status_reg); end
    checks++; if (cpu_if.event_data !== 8'h06) begin errors++; $display("FAIL ovf_head got %h exp 06", cpu_if.event_data); end
    for (int i = 0; i < FD - 1; i++) pop_one();
    checks++; if (cpu_if.event_data !== 8'h02) begin errors++; $display("FAIL ovf_tail got %h exp 02", cpu_if.event_data); end
    pop_one();
    pop_one();
    checks++; if (cpu_if.status_reg !== 8'h04) begin errors++; $display("FAIL ovf_drained got %h exp 04", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_held got %b exp 1", cpu_if.irq); end
    clear_status();
    tick(1);
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL ovf_clear got %h exp 00", cpu_if.status_reg); end
    checks++; if (cpu_if.irq !== 1'b0) begin errors++; $display("FAIL ovf_clear_irq got %b exp 0", cpu_if.irq); end
  endtask

  task automatic test_position_wrap;
    do_reset('0, '0);
    for (int i = 0; i < 129; i++) begin
      step(0, 2'b01); step(0, 2'b11); step(0, 2'b10); step(0, 2'b00);
    end
    checks++; if (position[7:0] !== EXP_POS_WRAP) begin errors++; $display("FAIL wrap_pos0 got %h exp %h", position[7:0], EXP_POS_WRAP); end
    checks++; if (position[15:8] !== 8'h00) begin errors++; $display("FAIL wrap_pos1 got %h exp 00", position[15:8]); end
    checks++; if (cpu_if.status_reg !== 8'h87) begin errors++; $display("FAIL wrap_status got %h exp 87", cpu_if.status_reg); end
    enc_a[0] = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cpu_if.status_reg !== 8'h00) begin errors++; $display("FAIL midrst_status got %h exp 00", cpu_if.status_reg); end
    checks++; if (cpu_if.event_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h exp 00", cpu_if.event_data); end
    checks++; if (cpu_if.irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp 0", cpu_if.irq); end
    checks++; if (position !== 16'h0000) begin errors++; $display("FAIL midrst_position got %h exp 0000", position); end
    tick(2);
    rst_n = 1'b1;
    tick(HOLD);
  endtask

  initial begin
    cpu_if.event_rd_stb  = 1'b0;
    cpu_if.status_rd_stb = 1'b0;
    test_reset();
    test_cw_detent();
    test_glitch_and_err();
    test_switch_simul();
    test_fifo_overflow();
    test_position_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/front_panel_encoders.md
Name: front_panel_encoders

Overview:
- Multi-channel successor to the single rotary-encoder front-panel interface.
- Per channel: synchronises, debounces and quadrature-decodes NUM_ENC encoders plus push switches.
- Queues timestamp-free event words in a shared FIFO for the CPU and keeps per-channel signed detent position counters.
- Sits between the front-panel pins and the CPU register interface, on the same clk domain as the SPI register block.

Parameters:
NUM_ENC, 2, number of encoder channels (1..8)
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required before an input change is accepted (>=2)
FIFO_DEPTH, 8, event FIFO entries (power of 2, 2..16)
POS_WIDTH, 8, width of each two's-complement position counter

Ports:
clk  in  1  system clock
spi_reset_n  in  1  asynchronous active-low reset
encoder_A  in  NUM_ENC  raw quadrature A per channel
encoder_B  in  NUM_ENC  raw quadrature B per channel
encoder_sw  in  NUM_ENC  raw push switch per channel, 1 = pressed
event_rd_stb  in  1  one-cycle pulse: pop FIFO head
event_data  out  8  FIFO head word (valid when status_reg[0]=1)
status_rd_stb  in  1  one-cycle pulse: clear sticky status bits
status_reg  out  8  FIFO/decoder status
position  out  NUM_ENC*POS_WIDTH  channel n position at [n*POS_WIDTH +: POS_WIDTH]
irq  out  1  high while FIFO not empty or any sticky bit set

Behaviour:
- Reset (async assert, sync release): FIFO empty, event_data=0, status_reg=0, positions=0, irq=0, all debouncers in init state, pending slots clear.
- Input path: 2-flop synchroniser per raw bit. Per-bit debounce counter restarts on any change of synchronised value. Value accepted after DEBOUNCE_CYCLES stable cycles.
- Init: the first accepted A/B/sw values after reset load decoder/switch state with no event.
- Decoder, state = {B,A}:
  - cw sequence 00->01->11->10->00; ccw is the reverse.
  - Valid single-bit transition = step. click=1 when the new state is 00. dir=1 for cw.
  - Two-bit change (00<->11, 01<->10): no event, state updated, sticky decode_err set.
- Switch: each accepted level change = switch event.
- Event word:
  - [7:5] channel index
  - [4] click
  - [3] dir
  - [2] switch level
  - [1] type (0 = rotation, 1 = switch)
  - [0] 0
  - Rotation and switch on the same channel in the same cycle: rotation word first, switch word queued behind it in the channel's second pending slot.
- Arbitration:
  - Each channel has a 2-entry pending buffer.
  - Each cycle, at most one word is pushed: lowest-index channel with a pending entry.
  - Push-to-visible latency 1 cycle after arbitration.
  - Pending buffer full when a new event arrives: drop the event, set sticky overflow.
- FIFO:
  - Push when full: word dropped, sticky overflow set.
  - event_rd_stb when empty: ignored.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pointers wrap modulo FIFO_DEPTH.
- status_reg:
  - [0] not empty
  - [1] full
  - [2] overflow (sticky)
  - [3] decode_err (sticky)
  - [7:4] count, saturated at 15
  - status_rd_stb clears [3:2]. A set in the same cycle as a clear wins.
- irq = status_reg[0] | status_reg[2] | status_reg[3], registered.

Optional Feature:
FP_POSITION_EN
- Defined:
  - Each click increments (cw) or decrements (ccw) the channel's position counter in the cycle after decode.
  - Counters wrap modulo 2^POS_WIDTH.
  - Updates are independent of FIFO state; dropped events still count.
- Undefined: counter logic omitted, position tied to 0.

Test Plan:
- Reset, hold inputs 11 for 2*DEBOUNCE_CYCLES -> no FIFO entry, status_reg=0x00, irq=0.
- Channel 1 cw full detent 00->01->11->10->00 (each held > DEBOUNCE_CYCLES) -> 4 words, last = 0x38; count=4; position ch1 = +1 with FP_POSITION_EN, 0 without.
- Glitch on A shorter than DEBOUNCE_CYCLES -> no event. Direct 00->11 -> no event, status_reg[3]=1, cleared by status_rd_stb.
- Ch0 and ch1 switch press in the same accepted cycle -> FIFO order 0x06 then 0x26.
- Generate FIFO_DEPTH+3 events with no reads -> full=1, overflow=1, count=FIFO_DEPTH; pop all -> empty, irq remains until status_rd_stb.
- With FP_POSITION_EN, POS_WIDTH=8: 129 cw clicks from 0 -> position=0x81 (wrap); assert spi_reset_n mid-sequence -> all outputs 0 immediately.
